// File: rtl/data_mem_responder.sv
// Data-memory responder: sampled request, programmable wait states, range/alignment
// checking, single-cycle ready pulse and a saturating error counter over an internal RAM.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_memory_a,
    input  logic [31:0] data_memory_out_v,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    output logic [31:0] data_memory_in_v,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_error,
    output logic [7:0]  err_count
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned SPAN_LOG2 = ADDR_WIDTH + 2;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [7:0]              err_count_q, err_count_d;
    logic                    enter_resp;

    logic [31:0]             ram_q [DEPTH];

    logic [31:0]             offset;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   req_idx;

    // Offset is only meaningful when not below base; the shift test cannot wrap.
    always_comb begin
        offset  = data_memory_a - BASE_ADDR;
        req_idx = offset[ADDR_WIDTH+1:2];
        req_err = (data_memory_a[1:0] != 2'b00)
               || (data_memory_a < BASE_ADDR)
               || ((offset >> SPAN_LOG2) != 32'd0)
               || (data_memory_read && data_memory_write);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        err_count_d = err_count_q;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_memory_read || data_memory_write) begin
                    idx_d   = req_idx;
                    wdata_d = data_memory_out_v;
                    write_d = data_memory_write;
                    err_d   = req_err;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Response data and error count are settled as RESP is entered so they align with mem_ready.
        if (enter_resp) begin
            if (err_d) begin
                rdata_d = 32'd0;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else if (!write_d) begin
                rdata_d = ram_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            err_count_q <= err_count_d;
        end
    end

    // RAM is never cleared; the write commits on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_RESP) && write_q && !err_q) begin
            ram_q[idx_q] <= wdata_q;
        end
    end

    assign data_memory_in_v = rdata_q;
    assign mem_ready        = (state_q == S_RESP);
    assign mem_error        = (state_q == S_RESP) && err_q;
    assign mem_busy         = (state_q != S_IDLE);
    assign err_count        = err_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (2, 3 and 0 wait states) share one request bus.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;

    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        merr  [3];
    logic [7:0]  ecnt  [3];

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
        .clk(clk), .reset(reset), .data_memory_a(addr), .data_memory_out_v(wdata),
        .data_memory_read(rd), .data_memory_write(wr), .data_memory_in_v(rdata[0]),
        .mem_ready(rdy[0]), .mem_busy(busy[0]), .mem_error(merr[0]), .err_count(ecnt[0]));

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .clk(clk), .reset(reset), .data_memory_a(addr), .data_memory_out_v(wdata),
        .data_memory_read(rd), .data_memory_write(wr), .data_memory_in_v(rdata[1]),
        .mem_ready(rdy[1]), .mem_busy(busy[1]), .mem_error(merr[1]), .err_count(ecnt[1]));

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .reset(reset), .data_memory_a(addr), .data_memory_out_v(wdata),
        .data_memory_read(rd), .data_memory_write(wr), .data_memory_in_v(rdata[2]),
        .mem_ready(rdy[2]), .mem_busy(busy[2]), .mem_error(merr[2]), .err_count(ecnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic do_access(input int s, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output int lat, output logic [31:0] rdat,
                             output logic er);
        addr  = a;
        wdata = d;
        rd    = r;
        wr    = w;
        lat   = -1;
        rdat  = 32'hxxxx_xxxx;
        er    = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy[s]) begin
                lat  = c;
                rdat = rdata[s];
                er   = merr[s];
                break;
            end
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    int          lat;
    logic [31:0] rv;
    logic        er;
    logic [5:0]  pat;
    logic [31:0] seen [3];
    int          k;
    int          late_rdy;

    initial begin
        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        rd    = 1'b0;
        wr    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_error", 32'(merr[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_ecnt",  32'(ecnt[0]), 32'd0);
        @(posedge clk); #1;

        // Write then read back with two wait states
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rv, er);
        check("wr10_lat", 32'(lat), 32'd3);
        check("wr10_err", 32'(er), 32'd0);
        @(negedge clk);
        check("ready_one_cycle", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rv, er);
        check("rd10_lat",  32'(lat), 32'd3);
        check("rd10_data", rv, 32'hDEADBEEF);
        check("rd10_err",  32'(er), 32'd0);

        // Misaligned read
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, rv, er);
        check("mis_err",  32'(er), 32'd1);
        check("mis_data", rv, 32'd0);
        check("mis_lat",  32'(lat), 32'd3);
        @(negedge clk);
        check("mis_ecnt", 32'(ecnt[0]), 32'd1);
        @(posedge clk); #1;

        // Out-of-range write must not alias onto word 0
        do_access(0, 1'b0, 1'b1, 32'h0,   32'h1111_1111, lat, rv, er);
        do_access(0, 1'b0, 1'b1, 32'hFFC, 32'hAAAA_AAAA, lat, rv, er);
        check("wr_hold_rdata", rv, 32'd0);
        do_access(0, 1'b0, 1'b1, 32'h1000, 32'h55, lat, rv, er);
        check("oor_err", 32'(er), 32'd1);
        @(negedge clk);
        check("oor_ecnt", 32'(ecnt[0]), 32'd2);
        @(posedge clk); #1;
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, rv, er);
        check("rd0_data", rv, 32'h1111_1111);
        do_access(0, 1'b1, 1'b0, 32'hFFC, 32'h0, lat, rv, er);
        check("rdffc_data", rv, 32'hAAAA_AAAA);
        check("rdffc_err",  32'(er), 32'd0);

        // Both strobes: error, no write
        do_access(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, lat, rv, er);
        check("wr20_hold_rdata", rv, 32'hAAAA_AAAA);
        do_access(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, lat, rv, er);
        check("both_err",  32'(er), 32'd1);
        check("both_data", rv, 32'd0);
        @(negedge clk);
        check("both_ecnt", 32'(ecnt[0]), 32'd3);
        @(posedge clk); #1;
        do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rv, er);
        check("rd20_data", rv, 32'h0BAD_F00D);

        // Reset abandons a write in flight (three wait states)
        idle(8);
        do_access(1, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, lat, rv, er);
        check("ws3_wr_lat", 32'(lat), 32'd4);
        do_access(1, 1'b1, 1'b0, 32'h40, 32'h0, lat, rv, er);
        check("ws3_rd_data", rv, 32'hCAFE_F00D);
        addr  = 32'h40;
        wdata = 32'h1234_5678;
        wr    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        wr    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",  32'(busy[1]), 32'd0);
        check("abort_ready", 32'(rdy[1]), 32'd0);
        check("abort_error", 32'(merr[1]), 32'd0);
        check("abort_rdata", rdata[1], 32'd0);
        check("abort_ecnt",  32'(ecnt[1]), 32'd0);
        late_rdy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[1]) late_rdy++;
        end
        check("abort_no_ready", 32'(late_rdy), 32'd0);
        @(posedge clk); #1;
        do_access(1, 1'b1, 1'b0, 32'h40, 32'h0, lat, rv, er);
        check("abort_old_data", rv, 32'hCAFE_F00D);

        // Zero wait states: back-to-back reads with strobe held
        idle(8);
        do_access(2, 1'b0, 1'b1, 32'h0, 32'hA0, lat, rv, er);
        check("ws0_wr_lat", 32'(lat), 32'd1);
        do_access(2, 1'b0, 1'b1, 32'h4, 32'hA4, lat, rv, er);
        do_access(2, 1'b0, 1'b1, 32'h8, 32'hA8, lat, rv, er);
        idle(8);
        addr = 32'h0;
        rd   = 1'b1;
        pat  = '0;
        k    = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pat[c] = rdy[2];
            if (rdy[2] && k < 3) begin
                seen[k] = rdata[2];
                k++;
            end
            @(posedge clk); #1;
            if (c == 1) addr = 32'h4;
            if (c == 3) addr = 32'h8;
        end
        rd = 1'b0;
        check("b2b_ready_pattern", 32'(pat), 32'h2A);
        check("b2b_count", 32'(k), 32'd3);
        check("b2b_data0", seen[0], 32'hA0);
        check("b2b_data1", seen[1], 32'hA4);
        check("b2b_data2", seen[2], 32'hA8);

        // 300 misaligned reads saturate the error counter
        addr = 32'h1;
        rd   = 1'b1;
        repeat (600) @(posedge clk);
        #1 rd = 1'b0;
        @(negedge clk);
        check("sat_ecnt", 32'(ecnt[2]), 32'd255);
        @(posedge clk); #1;
        do_access(2, 1'b1, 1'b0, 32'h8, 32'h0, lat, rv, er);
        check("sat_good_data", rv, 32'hA8);
        @(negedge clk);
        check("sat_ecnt_hold", 32'(ecnt[2]), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
